dcsk_tx_framer: RTL

DCSK_TX_FRAMER -- requirements
Module: dcsk_tx_framer

---
 rtl/dcsk_tx_framer.sv | 99 +++++++++
 1 files changed

// File: rtl/dcsk_tx_framer.sv
// dcsk_tx_framer: DCSK serial chip framer (LFSR reference half, XNOR-keyed info half).
// Define DCSK_TX_PARITY_EN to append an even-parity symbol after the message bits.
module dcsk_tx_framer #(
    parameter int MSG_W  = 32,
    parameter int SF_MAX = 32,
    localparam int SF_W  = $clog2(SF_MAX) + 1
) (
    input  logic             i_clk,
    input  logic             i_arst,
    input  logic [15:0]      i_seed,
    input  logic             i_load_seed,
    input  logic [SF_W-1:0]  i_sf,
    input  logic [MSG_W-1:0] i_msg,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_abort,
    output logic             o_tx,
    output logic             o_tx_valid,
    output logic             o_busy,
    output logic             o_done
);
`ifdef DCSK_TX_PARITY_EN
    localparam int NBITS = MSG_W + 1;
`else
    localparam int NBITS = MSG_W;
`endif
    localparam int IDX_W = $clog2(SF_MAX);
    localparam int BIT_W = $clog2(NBITS + 1);

    typedef enum logic [1:0] {IDLE, REF, INFO, DONE} state_t;

    state_t           r_state, w_next;
    logic [15:0]      r_lfsr;
    logic [IDX_W-1:0] r_chip;
    logic [BIT_W-1:0] r_bit;
    logic [SF_W-1:0]  r_sf;
    logic [MSG_W-1:0] r_msg;
    logic             r_buf [SF_MAX];
    logic [NBITS-1:0] w_bits;
    logic [SF_W-1:0]  w_sf;
    logic             w_accept, w_last_chip, w_last_bit, w_msg_bit;

`ifdef DCSK_TX_PARITY_EN
    assign w_bits = {^r_msg, r_msg};
`else
    assign w_bits = r_msg;
`endif
    assign w_msg_bit   = |(w_bits & (NBITS'(1) << r_bit));
    assign w_accept    = i_valid && r_state == IDLE && !i_abort;
    assign w_sf        = (i_sf < SF_W'(2)) ? SF_W'(2) : (i_sf > SF_W'(SF_MAX)) ? SF_W'(SF_MAX) : i_sf;
    assign w_last_chip = {1'b0, r_chip} == r_sf - SF_W'(1);
    assign w_last_bit  = r_bit == BIT_W'(NBITS - 1);

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        o_ready    = r_state == IDLE;
        o_tx_valid = r_state == REF || r_state == INFO;
        o_busy     = r_state != IDLE;
        o_done     = r_state == DONE;
        o_tx       = r_state == REF ? r_lfsr[0] : r_state == INFO ? ~(r_buf[r_chip] ^ w_msg_bit) : 1'b0;
        if (r_state == IDLE)      w_next = w_accept ? REF : IDLE;
        else if (i_abort)         w_next = IDLE;
        else if (r_state == REF)  w_next = w_last_chip ? INFO : REF;
        else if (r_state == INFO) w_next = w_last_chip ? (w_last_bit ? DONE : REF) : INFO;
        else                      w_next = IDLE;
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_lfsr <= 16'hACE1;
            r_chip <= '0;
            r_bit  <= '0;
            r_sf   <= '0;
            r_msg  <= '0;
        end else begin
            // an all-zero LFSR would lock up, so a zero seed becomes 1
            if (r_state == IDLE && i_load_seed) r_lfsr <= (i_seed == 16'h0) ? 16'h0001 : i_seed;
            if (r_state == REF) r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
            if (w_accept) begin
                r_msg  <= i_msg;
                r_sf   <= w_sf;
                r_chip <= '0;
                r_bit  <= '0;
            end else if (o_tx_valid) begin
                r_chip <= w_last_chip ? '0 : r_chip + IDX_W'(1);
                if (r_state == INFO && w_last_chip) r_bit <= r_bit + BIT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (r_state == REF) r_buf[r_chip] <= r_lfsr[0];
    end
endmodule
